// File: rtl/pcie_tx_buffer.sv
// Transmit byte buffer: DEPTH-entry circular FIFO between the PCIe data source and the
// serializer, sequenced by a small link FSM with a sticky overflow error state.
module pcie_tx_buffer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [3:0]        CONTROL,
    input  logic [DATA_W-1:0] DATA,
    input  logic              VALID_OUT,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] Tx_Buffer,
    output logic              tx_valid,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              almost_full,
    output logic              error,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;

    state_t              state_reg;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr_reg;
    logic [ADDR_W-1:0]   rd_ptr_reg;
    logic [ADDR_W:0]     count_reg;
    logic [ADDR_W:0]     count_next;
    logic [3:0]          thr_reg;
    logic [DATA_W-1:0]   tx_buffer_reg;
    logic                tx_valid_reg;
    logic                error_reg;

    logic link_up;
    logic push_req;
    logic pop_go;
    logic overflow;
    logic push_go;

    assign fifo_full   = (count_reg == (ADDR_W+1)'(DEPTH));
    assign fifo_empty  = (count_reg == '0);
    assign almost_full = (5'(count_reg) >= 5'(thr_reg));

    assign link_up  = (state_reg == ST_IDLE) || (state_reg == ST_ACTIVE);
    assign push_req = link_up && VALID_OUT;
    assign pop_go   = (state_reg == ST_ACTIVE) && tx_ready && !fifo_empty;
    // A push into a full FIFO is only legal when a pop frees the head slot in the same cycle.
    assign overflow = push_req && fifo_full && !pop_go;
    assign push_go  = push_req && !overflow;

    always_comb begin
        count_next = count_reg;
        if (push_go && !pop_go) begin
            count_next = count_reg + (ADDR_W+1)'(1);
        end else if (pop_go && !push_go) begin
            count_next = count_reg - (ADDR_W+1)'(1);
        end
    end

    // Storage array kept free of reset so it maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (reset && push_go) begin
            mem[wr_ptr_reg] <= DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_reg     <= ST_RESET;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            thr_reg       <= 4'(DEPTH - 1);
            tx_buffer_reg <= '0;
            tx_valid_reg  <= 1'b0;
            error_reg     <= 1'b0;
        end else begin
            tx_valid_reg <= pop_go;
            if (pop_go) begin
                tx_buffer_reg <= mem[rd_ptr_reg];
                rd_ptr_reg    <= rd_ptr_reg + ADDR_W'(1);
            end
            if (push_go) begin
                wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
            end
            count_reg <= count_next;
            if (overflow) begin
                error_reg <= 1'b1;
            end

            case (state_reg)
                ST_RESET: state_reg <= ST_INIT;
                ST_INIT: begin
                    if (CONTROL == 4'd0 || 5'(CONTROL) > 5'(DEPTH)) begin
                        thr_reg <= 4'(DEPTH - 1);
                    end else begin
                        thr_reg <= CONTROL;
                    end
                    state_reg <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (overflow) begin
                        state_reg <= ST_ERROR;
                    end else if (!fifo_empty) begin
                        state_reg <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (overflow) begin
                        state_reg <= ST_ERROR;
                    end else if (fifo_empty) begin
                        state_reg <= ST_IDLE;
                    end
                end
                ST_ERROR: state_reg <= ST_ERROR;
                default:  state_reg <= ST_RESET;
            endcase
        end
    end

    assign Tx_Buffer = tx_buffer_reg;
    assign tx_valid  = tx_valid_reg;
    assign error     = error_reg;
    assign state     = state_reg;

endmodule

// File: tb/tb_pcie_tx_buffer.sv
// Bench for pcie_tx_buffer: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based behavioural model of the transmit buffer.
module tb_pcie_tx_buffer;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              CLK;
    logic              reset;
    logic [3:0]        CONTROL;
    logic [DATA_W-1:0] DATA;
    logic              VALID_OUT;
    logic              tx_ready;
    logic [DATA_W-1:0] Tx_Buffer;
    logic              tx_valid;
    logic              fifo_full;
    logic              fifo_empty;
    logic              almost_full;
    logic              error;
    logic [2:0]        state;

    pcie_tx_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK(CLK), .reset(reset), .CONTROL(CONTROL), .DATA(DATA),
        .VALID_OUT(VALID_OUT), .tx_ready(tx_ready), .Tx_Buffer(Tx_Buffer),
        .tx_valid(tx_valid), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .almost_full(almost_full), .error(error), .state(state)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: link mode, byte queue, threshold and output register.
    int         m_mode;
    logic [7:0] m_q[$];
    int         m_thr;
    logic [7:0] m_tx;
    logic       m_valid;
    logic       m_err;
    logic [7:0] out_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic v, input logic [7:0] d, input logic rdy);
        bit pop, push, ovf;
        int old_size;
        if (!rst) begin
            m_mode = 0; m_q.delete(); m_tx = 8'h00; m_valid = 1'b0; m_err = 1'b0; m_thr = DEPTH - 1;
        end else begin
            old_size = m_q.size();
            pop  = (m_mode == 3) && rdy && (old_size > 0);
            push = (m_mode == 2 || m_mode == 3) && v;
            ovf  = push && (old_size == DEPTH) && !pop;
            m_valid = pop;
            if (pop) m_tx = m_q.pop_front();
            if (push && !ovf) m_q.push_back(d);
            case (m_mode)
                0: m_mode = 1;
                1: begin
                    m_thr  = (CONTROL == 0 || int'(CONTROL) > DEPTH) ? DEPTH - 1 : int'(CONTROL);
                    m_mode = 2;
                end
                2, 3: begin
                    if (ovf) begin
                        m_mode = 4; m_err = 1'b1;
                    end else begin
                        m_mode = (old_size > 0) ? 3 : 2;
                    end
                end
                default: m_mode = 4;
            endcase
        end
    endtask

    // One clock: drive inputs, advance the model, then compare every output just after the edge.
    task automatic cycle(input logic rst, input logic v, input logic [7:0] d, input logic rdy);
        reset = rst; VALID_OUT = v; DATA = d; tx_ready = rdy;
        model_step(rst, v, d, rdy);
        @(posedge CLK);
        #1;
        check("state", 32'(state), 32'(m_mode));
        check("tx_valid", 32'(tx_valid), 32'(m_valid));
        check("Tx_Buffer", 32'(Tx_Buffer), 32'(m_tx));
        check("error", 32'(error), 32'(m_err));
        check("fifo_full", 32'(fifo_full), 32'(m_q.size() == DEPTH));
        check("fifo_empty", 32'(fifo_empty), 32'(m_q.size() == 0));
        check("almost_full", 32'(almost_full), 32'(m_q.size() >= m_thr));
        if (tx_valid === 1'b1) out_q.push_back(Tx_Buffer);
    endtask

    task automatic do_reset(input logic [3:0] ctl);
        CONTROL = ctl;
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    logic [7:0] exp_seq[$];

    initial begin
        reset = 1'b0; CONTROL = 4'd3; DATA = '0; VALID_OUT = 1'b0; tx_ready = 1'b0;

        // 1: reset sequencing with CONTROL=3
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);
        check("rst_state", 32'(state), 32'd0);
        check("rst_empty", 32'(fifo_empty), 32'd1);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check("init_state", 32'(state), 32'd1);
        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        check("idle_state", 32'(state), 32'd2);

        // 2: two-byte latency check
        out_q.delete();
        cycle(1'b1, 1'b1, 8'hA5, 1'b1);
        cycle(1'b1, 1'b1, 8'h3C, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check("lat_first", {23'd0, tx_valid, Tx_Buffer}, {23'd0, 1'b1, 8'hA5});
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check("lat_second", {23'd0, tx_valid, Tx_Buffer}, {23'd0, 1'b1, 8'h3C});
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check("lat_back_idle", 32'(state), 32'd2);

        // 3: fill with tx_ready low, then overflow
        do_reset(4'd3);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b1, 8'(i), 1'b0);
            if (i == 2) check("af_below_thr", 32'(almost_full), 32'd0);
            if (i == 3) check("af_at_thr", 32'(almost_full), 32'd1);
        end
        check("full_after_8", 32'(fifo_full), 32'd1);
        out_q.delete();
        cycle(1'b1, 1'b1, 8'h09, 1'b0);
        check("ovf_error", {29'd0, error, state}, {29'd0, 1'b1, 3'd4});
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check("err_no_output", 32'(out_q.size()), 32'd0);

        // 4: full FIFO with concurrent push/pop, pointers wrap
        do_reset(4'd3);
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b1, 8'(i), 1'b0);
        out_q.delete();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 8'(8'h10 + i), 1'b1);
        check("wrap_no_error", 32'(error), 32'd0);
        check("wrap_full", 32'(fifo_full), 32'd1);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        exp_seq.delete();
        for (int i = 1; i <= 8; i++) exp_seq.push_back(8'(i));
        for (int i = 0; i < 8; i++) exp_seq.push_back(8'(8'h10 + i));
        check("wrap_count", 32'(out_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (i < out_q.size()) check("wrap_order", 32'(out_q[i]), 32'(exp_seq[i]));
        end

        // 5: reset with bytes queued
        do_reset(4'd3);
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'(8'hC0 + i), 1'b0);
        cycle(1'b0, 1'b1, 8'hEE, 1'b1);
        check("midrst", {27'd0, tx_valid, fifo_empty, state}, {27'd0, 1'b0, 1'b1, 3'd0});
        out_q.delete();
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        cycle(1'b1, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 8'h00, 1'b1);
        check("no_stale", 32'(out_q.size()), 32'd0);

        // 6: out-of-range thresholds fall back to DEPTH-1
        for (int t = 0; t < 2; t++) begin
            do_reset(t == 0 ? 4'd0 : 4'd12);
            for (int i = 1; i <= 7; i++) begin
                cycle(1'b1, 1'b1, 8'(i), 1'b0);
                if (i == 6) check("af_clamp_6", 32'(almost_full), 32'd0);
                if (i == 7) check("af_clamp_7", 32'(almost_full), 32'd1);
            end
        end

        // Randomized traffic including random thresholds and occasional resets
        do_reset(4'($urandom_range(0, 15)));
        for (int i = 0; i < 3000; i++) begin
            CONTROL = 4'($urandom_range(0, 15));
            cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 99) < 55),
                  8'($urandom), ($urandom_range(0, 99) < 60));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pcie_tx_buffer.md
Name: pcie_tx_buffer

Overview:
- Transmit-side byte buffer that sits directly downstream of the PCIe stimulus/data source.
- Accepts bytes on DATA when VALID_OUT is high and queues them in a DEPTH-entry circular FIFO.
- Drains bytes to the serializer via Tx_Buffer/tx_valid, paced by tx_ready.
- A small link-style FSM (RESET, INIT, IDLE, ACTIVE, ERROR) sequences the block. CONTROL supplies the almost-full threshold, latched in INIT.

Parameters:
DATA_W, 8, byte width of DATA and Tx_Buffer
DEPTH, 8, FIFO entries (power of two, max 16)
ADDR_W, 3, log2(DEPTH); pointer width

Ports:
CLK  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
CONTROL  input  4  almost-full threshold; sampled only in INIT
DATA  input  DATA_W  write byte
VALID_OUT  input  1  write strobe; DATA pushed on edge when high
tx_ready  input  1  downstream may accept a byte this cycle
Tx_Buffer  output  DATA_W  registered output byte
tx_valid  output  1  registered; Tx_Buffer holds a newly popped byte this cycle
fifo_full  output  1  count == DEPTH
fifo_empty  output  1  count == 0
almost_full  output  1  count >= thr
error  output  1  sticky overflow flag
state  output  3  FSM state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4

Behaviour:
- Reset is sampled at the rising edge while reset=0. It sets:
  - Tx_Buffer=0, tx_valid=0, error=0, state=RESET.
  - count, wr_ptr and rd_ptr = 0.
  - thr=DEPTH-1.
  - Reset has priority over every other event, including mid-transfer. FIFO contents are discarded logically; RAM need not be cleared.
- Flags fifo_full, fifo_empty and almost_full are combinational decodes of the registered count and thr.
- FSM transitions (one per edge):
  - RESET -> INIT on the first edge with reset=1.
  - INIT -> IDLE after exactly one cycle. At this edge thr := CONTROL, except CONTROL==0 or CONTROL>DEPTH gives thr := DEPTH-1.
  - IDLE -> ACTIVE when registered count>0.
  - ACTIVE -> IDLE when registered count==0.
  - IDLE/ACTIVE -> ERROR on overflow (defined below).
  - ERROR is sticky; the only exit is reset.
- Push: in IDLE or ACTIVE, VALID_OUT=1 writes DATA at wr_ptr; wr_ptr and count increment.
  - VALID_OUT in RESET, INIT or ERROR is ignored.
- Pop: only in ACTIVE, with tx_ready=1 and count>0. Reads rd_ptr into Tx_Buffer, sets tx_valid=1 next cycle, and increments rd_ptr while count decrements.
  - In any other cycle tx_valid=0 next cycle and Tx_Buffer holds its value.
- Simultaneous push and pop: both performed and count unchanged. This is legal even when full; the popped byte is the old head.
- Overflow: push with count==DEPTH and no pop in the same cycle.
  - Byte is dropped.
  - error=1 and state=ERROR next edge.
  - In ERROR there are no pushes or pops, tx_valid=0, and Tx_Buffer holds.
- Pointers wrap modulo DEPTH. count is ADDR_W+1 bits and never exceeds DEPTH.
- Latency: a byte pushed into an empty FIFO at edge k is seen as follows:
  - state=ACTIVE after edge k+1.
  - Popped at edge k+2 if tx_ready=1, giving Tx_Buffer=byte and tx_valid=1 after edge k+2.
  - Back-to-back pops then stream one byte per cycle.
- Byte order on Tx_Buffer equals push order (strict FIFO).

Test Plan:
1. Hold reset=0 for 2 edges with CONTROL=4'd3, then release.
   - state reads 0 during reset, then 1 for one cycle, then 2.
   - All outputs 0, fifo_empty=1, thr=3.
2. From IDLE with tx_ready=1, push 0xA5 at edge k, then 0x3C at k+1.
   - tx_valid=1 with Tx_Buffer=0xA5 after edge k+2, then 0x3C after k+3.
   - tx_valid=0 afterwards; state returns to 2 once count reaches 0.
3. With tx_ready=0 and thr=3, push 0x01..0x08.
   - almost_full rises after the 3rd push; fifo_full=1 after the 8th.
   - A 9th push (0x09) sets error=1 and state=4; the byte is never output.
   - Raising tx_ready produces no tx_valid until reset.
4. With FIFO full and tx_ready=1, push 0x10..0x17 on consecutive cycles.
   - No error; count stays 8; pointers wrap.
   - Output sequence is 0x01..0x08 then 0x10..0x17 in order.
5. Assert reset=0 mid-stream with 5 bytes queued.
   - Next edge: all reset values, count=0.
   - After re-init, no stale byte appears on Tx_Buffer.
6. Release reset with CONTROL=4'd0, then separately with CONTROL=4'd12.
   - thr=7 in both cases; almost_full asserts at count 7.
